// File: rtl/arith_selftest.sv
`default_nettype none
// ============================================================================
// Module      : arith_selftest
// Description : Self-checking arithmetic cell. Issues a deterministic operand
//               sequence into a registered datapath (add i8, add i8v4 or
//               add_mul i8), compares each result against an independent
//               golden model and reports sticky fail / finish flags.
// Revision    : 1.0 - initial release
// ============================================================================
module arith_selftest #(
    parameter int OP          = 0,
    parameter int NUM_VECTORS = 16,
    parameter int INJECT_AT   = 256
) (
    input  logic clock,
    input  logic reset,
    output logic fail,
    output logic finish
);

    // Datapath latency: one result stage for the adds, product + sum for add_mul
    localparam int         c_LAT     = (OP == 2) ? 2 : 1;
    localparam logic [7:0] c_LAST    = 8'(NUM_VECTORS - 1);
    localparam bit         c_INJ_EN  = (INJECT_AT >= 0) && (INJECT_AT < NUM_VECTORS);
    localparam logic [7:0] c_INJ_IDX = 8'(INJECT_AT);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    logic [1:0]       r_state;
    logic [7:0]       r_idx;
    logic             r_fail;
    logic             r_finish;
    logic [c_LAT-1:0] r_vld;
    logic [7:0]       r_vidx [c_LAT];

    logic             w_issue;
    logic             w_out_vld;
    logic [7:0]       w_out_idx;
    logic [31:0]      w_dp;
    logic [31:0]      w_gold;
    logic             w_inj;
    logic             w_mis;

    assign w_out_vld = r_vld[c_LAT-1];
    assign w_out_idx = r_vidx[c_LAT-1];

    // A mismatch halts issuing on the very edge that records it
    assign w_issue = (r_state == c_ST_RUN) && !w_mis;

    assign w_inj = c_INJ_EN && (w_out_idx == c_INJ_IDX);
    assign w_mis = w_out_vld && ((w_dp ^ {31'b0, w_inj}) != w_gold);

    assign fail   = r_fail;
    assign finish = r_finish;

    // Control FSM, issue index, valid/index tracking and sticky status flags
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= c_ST_RUN;
            r_idx    <= 8'd0;
            r_fail   <= 1'b0;
            r_finish <= 1'b0;
            r_vld    <= '0;
            for (int j = 0; j < c_LAT; j++) begin
                r_vidx[j] <= 8'd0;
            end
        end else begin
            r_fail   <= r_fail | w_mis;
            // A mismatch on the last vector ends the run on the same edge
            r_finish <= r_finish | (r_state == c_ST_DONE) |
                        (w_mis && (w_out_idx == c_LAST));

            r_vld[0]  <= w_issue;
            r_vidx[0] <= r_idx;
            for (int j = 1; j < c_LAT; j++) begin
                r_vld[j]  <= r_vld[j-1];
                r_vidx[j] <= r_vidx[j-1];
            end
            // In-flight results are meaningless once a mismatch has been seen
            if (w_mis) begin
                r_vld <= '0;
            end

            case (r_state)
                c_ST_RUN: begin
                    if (w_mis) begin
                        r_state <= c_ST_DONE;
                    end else begin
                        r_idx <= r_idx + 8'd1;
                        if (r_idx == c_LAST) begin
                            r_state <= c_ST_DRAIN;
                        end
                    end
                end
                c_ST_DRAIN: begin
                    if (w_mis || (w_out_vld && (w_out_idx == c_LAST))) begin
                        r_state <= c_ST_DONE;
                    end
                end
                c_ST_DONE: begin
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_state <= c_ST_DONE;
                end
            endcase
        end
    end

    generate
        if (OP == 2) begin : g_op_addmul
            logic [7:0] r_a, r_b, r_c;
            logic [7:0] r_p, r_cd, r_y;
            logic [7:0] w_prod;
            logic [7:0] w_ga, w_gb, w_gc, w_gp;

            // Operands advance incrementally so they never reuse the golden multiplier
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_a <= 8'h11;
                    r_b <= 8'hC8;
                    r_c <= 8'h07;
                end else if (w_issue) begin
                    r_a <= r_a + 8'h25;
                    r_b <= r_b + 8'h5B;
                    r_c <= r_c + 8'h0F;
                end
            end

            assign w_prod = r_a * r_b;

            // Stage 1 registers the truncated product and delays c; stage 2 adds
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_p  <= 8'd0;
                    r_cd <= 8'd0;
                    r_y  <= 8'd0;
                end else begin
                    r_p  <= w_prod;
                    r_cd <= r_c;
                    r_y  <= r_p + r_cd;
                end
            end

            assign w_dp   = {24'b0, r_y};
            assign w_ga   = w_out_idx * 8'h25 + 8'h11;
            assign w_gb   = w_out_idx * 8'h5B + 8'hC8;
            assign w_gc   = w_out_idx * 8'h0F + 8'h07;
            assign w_gp   = w_ga * w_gb;
            assign w_gold = {24'b0, w_gp + w_gc};
        end else if (OP == 1) begin : g_op_vec
            for (genvar k = 0; k < 4; k++) begin : g_lane
                localparam logic [7:0] c_A_OFS = 8'(64 * k);
                localparam logic [7:0] c_B_OFS = 8'(33 * k);

                logic [7:0] r_a, r_b, r_y;
                logic [7:0] w_ga, w_gb;

                // Per-lane operands, each lane starting at its own offset
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_a <= 8'h11 + c_A_OFS;
                        r_b <= 8'hC8 + c_B_OFS;
                    end else if (w_issue) begin
                        r_a <= r_a + 8'h25;
                        r_b <= r_b + 8'h5B;
                    end
                end

                // Lane adder is 8 bits wide, so no carry can leak into the next lane
                always_ff @(posedge clock or posedge reset) begin
                    if (reset) begin
                        r_y <= 8'd0;
                    end else begin
                        r_y <= r_a + r_b;
                    end
                end

                assign w_dp[8*k +: 8]   = r_y;
                assign w_ga             = w_out_idx * 8'h25 + 8'h11 + c_A_OFS;
                assign w_gb             = w_out_idx * 8'h5B + 8'hC8 + c_B_OFS;
                assign w_gold[8*k +: 8] = w_ga + w_gb;
            end
        end else begin : g_op_add
            logic [7:0] r_a, r_b, r_y;
            logic [7:0] w_ga, w_gb;

            // Scalar operands stepped once per issued vector
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_a <= 8'h11;
                    r_b <= 8'hC8;
                end else if (w_issue) begin
                    r_a <= r_a + 8'h25;
                    r_b <= r_b + 8'h5B;
                end
            end

            // Single registered 8-bit wrap-around add
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    r_y <= 8'd0;
                end else begin
                    r_y <= r_a + r_b;
                end
            end

            assign w_dp   = {24'b0, r_y};
            assign w_ga   = w_out_idx * 8'h25 + 8'h11;
            assign w_gb   = w_out_idx * 8'h5B + 8'hC8;
            assign w_gold = {24'b0, w_ga + w_gb};
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_arith_selftest.sv
`default_nettype none
// ============================================================================
// Module      : tb_arith_selftest
// Description : Self-checking bench for arith_selftest. Runs six instances
//               (three operations, injection, single vector, final-vector
//               injection) and scoreboards datapath outputs and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arith_selftest;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic reset2 = 1'b1;

    logic fail0, fail1, fail2, fail3, fail4, fail5;
    logic finish0, finish1, finish2, finish3, finish4, finish5;

    int npass  = 0;
    int ncheck = 0;
    int e      = 0;
    int e2     = 0;

    logic [39:0] q0[$];
    logic [39:0] q1[$];
    logic [39:0] q2[$];

    always #5 clock = ~clock;

    arith_selftest #(.OP(0), .NUM_VECTORS(16), .INJECT_AT(256)) dut0 (
        .clock(clock), .reset(reset), .fail(fail0), .finish(finish0));
    arith_selftest #(.OP(1), .NUM_VECTORS(16), .INJECT_AT(256)) dut1 (
        .clock(clock), .reset(reset), .fail(fail1), .finish(finish1));
    arith_selftest #(.OP(2), .NUM_VECTORS(16), .INJECT_AT(256)) dut2 (
        .clock(clock), .reset(reset2), .fail(fail2), .finish(finish2));
    arith_selftest #(.OP(0), .NUM_VECTORS(16), .INJECT_AT(5)) dut3 (
        .clock(clock), .reset(reset), .fail(fail3), .finish(finish3));
    arith_selftest #(.OP(0), .NUM_VECTORS(1), .INJECT_AT(256)) dut4 (
        .clock(clock), .reset(reset), .fail(fail4), .finish(finish4));
    arith_selftest #(.OP(0), .NUM_VECTORS(4), .INJECT_AT(3)) dut5 (
        .clock(clock), .reset(reset), .fail(fail5), .finish(finish5));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncheck++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Reference result for vector i, straight from the stimulus formulas
    function automatic logic [31:0] exp_y(input int op, input int i);
        logic [7:0]  a, b, c;
        logic [31:0] r;
        a = 8'(i * 37 + 17);
        b = 8'(i * 91 + 200);
        c = 8'(i * 15 + 7);
        r = '0;
        case (op)
            0: r[7:0] = 8'(int'(a) + int'(b));
            1: for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(int'(a) + 64 * k + int'(b) + 33 * k);
            default: r[7:0] = 8'(int'(a) * int'(b) + int'(c));
        endcase
        return r;
    endfunction

    task automatic sb_cmp(input string tag, input bit have, input logic [39:0] ent,
                          input logic [7:0] idx, input logic [31:0] dp);
        check({tag, "_expected_output"}, {31'b0, have}, 32'd1);
        if (have) begin
            check({tag, "_idx"}, {24'b0, idx}, {24'b0, ent[39:32]});
            check({tag, "_data"}, dp, ent[31:0]);
        end
    endtask

    // Compare status flags against the edge-count model and pop any datapath outputs
    task automatic sample();
        logic [39:0] ent;
        check("d0_fail", {31'b0, fail0}, 32'd0);
        check("d0_finish", {31'b0, finish0}, {31'b0, e >= 18});
        check("d1_fail", {31'b0, fail1}, 32'd0);
        check("d1_finish", {31'b0, finish1}, {31'b0, e >= 18});
        check("d2_fail", {31'b0, fail2}, 32'd0);
        check("d2_finish", {31'b0, finish2}, {31'b0, e2 >= 19});
        check("d3_fail", {31'b0, fail3}, {31'b0, e >= 7});
        check("d3_finish", {31'b0, finish3}, {31'b0, e >= 8});
        check("d4_fail", {31'b0, fail4}, 32'd0);
        check("d4_finish", {31'b0, finish4}, {31'b0, e >= 3});
        check("d5_fail", {31'b0, fail5}, {31'b0, e >= 5});
        check("d5_finish", {31'b0, finish5}, {31'b0, e >= 5});

        if (dut0.w_out_vld) begin
            if (q0.size() > 0) begin ent = q0.pop_front(); sb_cmp("d0", 1'b1, ent, dut0.w_out_idx, dut0.w_dp); end
            else sb_cmp("d0", 1'b0, '0, dut0.w_out_idx, dut0.w_dp);
            if (dut0.w_out_idx == 8'd0) check("d0_vec0", dut0.w_dp, 32'h0000_00D9);
            if (dut0.w_out_idx == 8'd1) check("d0_vec1", dut0.w_dp, 32'h0000_0059);
        end
        if (dut1.w_out_vld) begin
            if (q1.size() > 0) begin ent = q1.pop_front(); sb_cmp("d1", 1'b1, ent, dut1.w_out_idx, dut1.w_dp); end
            else sb_cmp("d1", 1'b0, '0, dut1.w_out_idx, dut1.w_dp);
            if (dut1.w_out_idx == 8'd0) check("d1_vec0", dut1.w_dp, 32'hFC9B_3AD9);
        end
        if (dut2.w_out_vld) begin
            if (q2.size() > 0) begin ent = q2.pop_front(); sb_cmp("d2", 1'b1, ent, dut2.w_out_idx, dut2.w_dp); end
            else sb_cmp("d2", 1'b0, '0, dut2.w_out_idx, dut2.w_dp);
            if (dut2.w_out_idx == 8'd0) check("d2_vec0", dut2.w_dp, 32'h0000_004F);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            q0.push_back({8'(i), exp_y(0, i)});
            q1.push_back({8'(i), exp_y(1, i)});
            q2.push_back({8'(i), exp_y(2, i)});
        end

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_fail0", {31'b0, fail0}, 32'd0);
        check("rst_finish0", {31'b0, finish0}, 32'd0);
        check("rst_fail2", {31'b0, fail2}, 32'd0);
        check("rst_finish2", {31'b0, finish2}, 32'd0);
        check("rst_fail3", {31'b0, fail3}, 32'd0);
        check("rst_finish3", {31'b0, finish3}, 32'd0);
        check("rst_vld0", {31'b0, dut0.w_out_vld}, 32'd0);
        reset  = 1'b0;
        reset2 = 1'b0;

        for (int k = 1; k <= 35; k++) begin
            @(posedge clock);
            e++;
            if (!reset2) e2++;
            @(negedge clock);
            sample();
            if (e == 10) begin
                // Abort dut2 mid-run; its outputs must clear without a clock edge
                #2 reset2 = 1'b1;
                #1;
                check("midrst_fail2", {31'b0, fail2}, 32'd0);
                check("midrst_finish2", {31'b0, finish2}, 32'd0);
                e2 = 0;
                q2.delete();
                for (int i = 0; i < 16; i++) q2.push_back({8'(i), exp_y(2, i)});
            end
            if (e == 11) reset2 = 1'b0;
        end

        check("d0_all_outputs", q0.size(), 32'd0);
        check("d1_all_outputs", q1.size(), 32'd0);
        check("d2_all_outputs", q2.size(), 32'd0);

        // Asynchronous clear of sticky flags, mid-cycle
        @(negedge clock);
        #2;
        reset  = 1'b1;
        reset2 = 1'b1;
        #1;
        check("async_finish2", {31'b0, finish2}, 32'd0);
        check("async_fail3", {31'b0, fail3}, 32'd0);
        check("async_finish3", {31'b0, finish3}, 32'd0);
        check("async_finish0", {31'b0, finish0}, 32'd0);
        check("async_fail5", {31'b0, fail5}, 32'd0);

        $display("%0d/%0d checks passed", npass, ncheck);
        $finish;
    end

endmodule
`default_nettype wire
